// File: rtl/alarm_check_service.sv
// Alarm check service: rings on MM:SS match, dismissed by a 10-switch game.
// Define ALARM_SNOOZE_EN to add the SNOOZE state driven by push_u.
module alarm_check_service #(
  parameter logic [9:0] LFSR_SEED      = 10'h2A5,
  parameter int         BLINK_BIT      = 23,
  parameter int         RING_TIMEOUT_S = 60,
  parameter int         GAME_TIMEOUT_S = 30,
  parameter int         SNOOZE_S       = 300
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        spdt4,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_valid,
  input  logic        push_m,
  input  logic        push_u,
  input  logic [9:0]  game_sw,
  output logic [9:0]  game_led,
  output logic        ringing,
  output logic [2:0]  alarm_state,
  output logic        finish4,
  output logic [3:0]  miss_count
);

  typedef enum logic [2:0] {
`ifdef ALARM_SNOOZE_EN
    S_SNOOZE = 3'b011,
`endif
    S_IDLE   = 3'b000,
    S_RING   = 3'b001,
    S_GAME   = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_m_s1;
  logic               r_m_s2;
  logic               r_m_d;
  logic [9:0]         r_sw_s1;
  logic [9:0]         r_sw_s2;
  logic [BLINK_BIT:0] r_cnt;
  logic [9:0]         r_lfsr;
  logic [9:0]         r_target;
  logic [8:0]         r_timer;
  logic [3:0]         r_miss;
  logic               r_armed;
  logic               r_finish;

  logic w_edge_m;
  logic w_edge_u;
  logic w_match;
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_latch;
  logic w_miss_inc;
  logic w_miss_clr;
  logic w_arm_clr;

  assign w_edge_m = r_m_s2 & ~r_m_d;
  assign w_match  = (current_time == alarm_time);

`ifdef ALARM_SNOOZE_EN
  logic r_u_s1;
  logic r_u_s2;
  logic r_u_d;

  assign w_edge_u = r_u_s2 & ~r_u_d;

  // Snooze button synchronizer and edge history
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_u_s1 <= 1'b0;
      r_u_s2 <= 1'b0;
      r_u_d  <= 1'b0;
    end else begin
      r_u_s1 <= push_u;
      r_u_s2 <= r_u_s1;
      r_u_d  <= r_u_s2;
    end
  end
`else
  logic w_unused_push_u;

  assign w_unused_push_u = push_u;
  assign w_edge_u        = 1'b0;
`endif

  // Synchronizers, blink counter and free-running LFSR
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_m_s1  <= 1'b0;
      r_m_s2  <= 1'b0;
      r_m_d   <= 1'b0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_m_s1  <= push_m;
      r_m_s2  <= r_m_s1;
      r_m_d   <= r_m_s2;
      r_sw_s1 <= game_sw;
      r_sw_s2 <= r_sw_s1;
      r_cnt   <= r_cnt + {{BLINK_BIT{1'b0}}, 1'b1};
      r_lfsr  <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  // Next state and datapath controls; push edges beat ticks
  always_comb begin
    w_next     = r_state;
    w_tmr_clr  = 1'b0;
    w_tmr_inc  = 1'b0;
    w_latch    = 1'b0;
    w_miss_inc = 1'b0;
    w_miss_clr = 1'b0;
    w_arm_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tick_1hz && spdt4 && alarm_valid &&
            r_armed && w_match) begin
          w_next     = S_RING;
          w_tmr_clr  = 1'b1;
          w_miss_clr = 1'b1;
          w_arm_clr  = 1'b1;
        end
      end
      S_RING: begin
        if (!spdt4) begin
          w_next = S_IDLE;
        end else if (w_edge_m) begin
          w_next    = S_GAME;
          w_latch   = 1'b1;
          w_tmr_clr = 1'b1;
`ifdef ALARM_SNOOZE_EN
        end else if (w_edge_u) begin
          w_next    = S_SNOOZE;
          w_tmr_clr = 1'b1;
`endif
        end else if (tick_1hz) begin
          if (r_timer == 9'(RING_TIMEOUT_S - 1)) begin
            w_next    = S_IDLE;
            w_tmr_clr = 1'b1;
          end else begin
            w_tmr_inc = 1'b1;
          end
        end
      end
      S_GAME: begin
        if (!spdt4) begin
          w_next = S_IDLE;
        end else if (w_edge_m) begin
          if (r_sw_s2 == r_target) begin
            w_next = S_DONE;
          end else begin
            w_miss_inc = 1'b1;
            w_latch    = 1'b1;
            w_tmr_clr  = 1'b1;
          end
        end else if (tick_1hz) begin
          if (r_timer == 9'(GAME_TIMEOUT_S - 1)) begin
            w_next    = S_RING;
            w_tmr_clr = 1'b1;
          end else begin
            w_tmr_inc = 1'b1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (!spdt4) begin
          w_next = S_IDLE;
        end else if (tick_1hz) begin
          if (r_timer == 9'(SNOOZE_S - 1)) begin
            w_next    = S_RING;
            w_tmr_clr = 1'b1;
          end else begin
            w_tmr_inc = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        if (!spdt4) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and finish pulse on DONE entry
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_finish <= (w_next == S_DONE) &&
                  (r_state != S_DONE);
    end
  end

  // Timer, target, miss counter and re-arm flag
  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_timer  <= '0;
      r_target <= '0;
      r_miss   <= '0;
      r_armed  <= 1'b1;
    end else begin
      if (w_tmr_clr) begin
        r_timer <= '0;
      end else if (w_tmr_inc) begin
        r_timer <= r_timer + 9'd1;
      end
      if (w_latch) begin
        r_target <= r_lfsr;
      end
      if (w_miss_clr) begin
        r_miss <= '0;
      end else if (w_miss_inc && (r_miss != 4'hF)) begin
        r_miss <= r_miss + 4'd1;
      end
      if (w_arm_clr) begin
        r_armed <= 1'b0;
      end else if (!w_match) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign ringing     = (r_state == S_RING) & r_cnt[BLINK_BIT];
  assign game_led    = (r_state == S_GAME) ? r_target : '0;
  assign alarm_state = r_state;
  assign finish4     = r_finish;
  assign miss_count  = r_miss;

endmodule
